// File: rtl/fifo_cmd_writer_pkg.sv
// rtl/fifo_cmd_writer_pkg.sv - shared state encoding, FIFO flag levels and default timing for the command FIFO writer
package fifo_cmd_writer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_STROBE  = 3'd2,
        ST_HOLD    = 3'd3,
        ST_RECOVER = 3'd4
    } wr_state_t;

    // Active-low full flag levels as seen on the synchronised nFF input.
    localparam logic FIFO_FULL     = 1'b0;
    localparam logic FIFO_NOT_FULL = 1'b1;

    // Defaults for a 120 MHz clk.
    localparam int DEF_WR_SETUP_TICKS    = 1;
    localparam int DEF_WR_PULSE_TICKS    = 3;
    localparam int DEF_WR_RECOVERY_TICKS = 3;

    // Terminal value of the 8-bit tick counter for a phase lasting n cycles.
    function automatic logic [7:0] last_tick(input int n);
        return 8'(n - 1);
    endfunction

endpackage

// File: rtl/fifo_cmd_writer_sync2.sv
// rtl/fifo_cmd_writer_sync2.sv - two-flop synchronizer with async active-low clear to 0
//
// Ports:
//   clk  - destination clock
//   nrst - asynchronous active-low reset, clears both flops to 0
//   d    - asynchronous input
//   q    - synchronised output, two clk edges behind d
module fifo_cmd_writer_sync2 (
    input  logic clk,
    input  logic nrst,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

// File: rtl/fifo_cmd_writer.sv
// rtl/fifo_cmd_writer.sv - writes local command bytes into an external async FIFO with timed write strobe
//
// Ports:
//   clk           - system clock
//   nrst          - asynchronous active-low reset
//   in_data       - command byte from local producer
//   in_valid      - producer has a byte
//   in_ready      - byte accepted on this cycle's rising edge (IDLE and FIFO not full)
//   nff_in        - FIFO active-low full flag, asynchronous to clk
//   fifo_data_out - registered data to FIFO D pins, held until the next accepted byte
//   fifo_data_oe  - registered output enable for the data pins
//   fifo_wr_n     - registered active-low write strobe
//   busy          - high whenever a write sequence is in progress
//   write_count   - completed writes, wrapping 16-bit counter
module fifo_cmd_writer
    import fifo_cmd_writer_pkg::*;
#(
    parameter int DATA_WIDTH        = 8,
    parameter int WR_SETUP_TICKS    = DEF_WR_SETUP_TICKS,
    parameter int WR_PULSE_TICKS    = DEF_WR_PULSE_TICKS,
    parameter int WR_RECOVERY_TICKS = DEF_WR_RECOVERY_TICKS
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  nff_in,
    output logic [DATA_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_data_oe,
    output logic                  fifo_wr_n,
    output logic                  busy,
    output logic [15:0]           write_count
);

    localparam logic [7:0] SETUP_LAST    = last_tick(WR_SETUP_TICKS);
    localparam logic [7:0] PULSE_LAST    = last_tick(WR_PULSE_TICKS);
    localparam logic [7:0] RECOVERY_LAST = last_tick(WR_RECOVERY_TICKS);

    wr_state_t             r_state;
    wr_state_t             w_next_state;
    logic [7:0]            r_tick;
    logic                  r_wr_n;
    logic                  r_oe;
    logic [DATA_WIDTH-1:0] r_data;
    logic [15:0]           r_write_count;
    logic                  w_nff_s;
    logic                  w_handshake;

    // Full flag is only trusted after two flops; reset state reads as full.
    fifo_cmd_writer_sync2 u_nff_sync (
        .clk  (clk),
        .nrst (nrst),
        .d    (nff_in),
        .q    (w_nff_s)
    );

    assign in_ready    = (r_state == ST_IDLE) && (w_nff_s == FIFO_NOT_FULL);
    assign w_handshake = in_valid && in_ready;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:    if (w_handshake)              w_next_state = ST_SETUP;
            ST_SETUP:   if (r_tick == SETUP_LAST)     w_next_state = ST_STROBE;
            ST_STROBE:  if (r_tick == PULSE_LAST)     w_next_state = ST_HOLD;
            ST_HOLD:                                  w_next_state = ST_RECOVER;
            ST_RECOVER: if (r_tick == RECOVERY_LAST)  w_next_state = ST_IDLE;
            default:                                  w_next_state = ST_IDLE;
        endcase
    end

    // Pin outputs are decoded from the next state and registered, so the
    // strobe and enable change exactly on the edge that enters each phase.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state       <= ST_IDLE;
            r_tick        <= 8'd0;
            r_wr_n        <= 1'b1;
            r_oe          <= 1'b0;
            r_data        <= '0;
            r_write_count <= 16'd0;
        end else begin
            r_state <= w_next_state;
            r_tick  <= (w_next_state != r_state) ? 8'd0 : r_tick + 8'd1;
            r_wr_n  <= (w_next_state != ST_STROBE);
            r_oe    <= (w_next_state == ST_SETUP) || (w_next_state == ST_STROBE) ||
                       (w_next_state == ST_HOLD);
            if (w_handshake) begin
                r_data <= in_data;
            end
            if (r_state == ST_HOLD) begin
                r_write_count <= r_write_count + 16'd1;
            end
        end
    end

    assign fifo_data_out = r_data;
    assign fifo_data_oe  = r_oe;
    assign fifo_wr_n     = r_wr_n;
    assign busy          = (r_state != ST_IDLE);
    assign write_count   = r_write_count;

endmodule

// File: tb/tb_fifo_cmd_writer.sv
// tb/tb_fifo_cmd_writer.sv - directed self-checking bench for fifo_cmd_writer
module tb_fifo_cmd_writer;

    logic        clk = 1'b0;
    logic        nrst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        nff_in;
    logic [7:0]  fifo_data_out;
    logic        fifo_data_oe;
    logic        fifo_wr_n;
    logic        busy;
    logic [15:0] write_count;

    logic [7:0]  in_data2;
    logic        in_valid2;
    logic        in_ready2;
    logic        nff_in2;
    logic [7:0]  fifo_data_out2;
    logic        fifo_data_oe2;
    logic        fifo_wr_n2;
    logic        busy2;
    logic [15:0] write_count2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fifo_cmd_writer dut (
        .clk           (clk),
        .nrst          (nrst),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .nff_in        (nff_in),
        .fifo_data_out (fifo_data_out),
        .fifo_data_oe  (fifo_data_oe),
        .fifo_wr_n     (fifo_wr_n),
        .busy          (busy),
        .write_count   (write_count)
    );

    fifo_cmd_writer #(
        .WR_SETUP_TICKS    (2),
        .WR_PULSE_TICKS    (1),
        .WR_RECOVERY_TICKS (4)
    ) dut2 (
        .clk           (clk),
        .nrst          (nrst),
        .in_data       (in_data2),
        .in_valid      (in_valid2),
        .in_ready      (in_ready2),
        .nff_in        (nff_in2),
        .fifo_data_out (fifo_data_out2),
        .fifo_data_oe  (fifo_data_oe2),
        .fifo_wr_n     (fifo_wr_n2),
        .busy          (busy2),
        .write_count   (write_count2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] bytes_q [3];
    int         hs_c [3];
    int         n_hs;
    int         low_cnt;
    int         falls;
    logic       prev_wr;
    logic       hs;

    initial begin
        nrst      = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        nff_in    = 1'b1;
        in_data2  = 8'h00;
        in_valid2 = 1'b0;
        nff_in2   = 1'b1;
        bytes_q   = '{8'h11, 8'h22, 8'h33};

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wr_n",  fifo_wr_n,     1);
        chk("rst_oe",    fifo_data_oe,  0);
        chk("rst_data",  fifo_data_out, 0);
        chk("rst_count", write_count,   0);
        chk("rst_busy",  busy,          0);
        chk("rst_ready", in_ready,      0);
        nrst = 1'b1;
        step();
        chk("sync1_ready", in_ready, 0);
        step();
        chk("sync2_ready", in_ready, 1);

        // reset in the middle of STROBE
        in_valid = 1'b1;
        in_data  = 8'hC3;
        step();
        in_valid = 1'b0;
        step();
        chk("mr_wr_fall", fifo_wr_n, 0);
        step();
        step();
        chk("mr_wr_low", fifo_wr_n, 0);
        #2 nrst = 1'b0;
        #1;
        chk("mr_wr_n",  fifo_wr_n,     1);
        chk("mr_oe",    fifo_data_oe,  0);
        chk("mr_busy",  busy,          0);
        chk("mr_count", write_count,   0);
        chk("mr_data",  fifo_data_out, 0);
        @(posedge clk);
        #1 nrst = 1'b1;
        chk("mr_ready0", in_ready, 0);
        step();
        chk("mr_ready1", in_ready, 0);
        step();
        chk("mr_ready2", in_ready, 1);
        chk("mr_count2", write_count, 0);

        // single write, default timing
        in_valid = 1'b1;
        in_data  = 8'hA5;
        step();
        in_valid = 1'b0;
        in_data  = 8'h00;
        for (int j = 0; j <= 8; j++) begin
            if (j > 0) step();
            chk($sformatf("sw_oe%0d", j),    fifo_data_oe,  (j <= 4) ? 1 : 0);
            chk($sformatf("sw_wr%0d", j),    fifo_wr_n,     (j >= 1 && j <= 3) ? 0 : 1);
            chk($sformatf("sw_rdy%0d", j),   in_ready,      (j == 8) ? 1 : 0);
            chk($sformatf("sw_cnt%0d", j),   write_count,   (j >= 5) ? 1 : 0);
            chk($sformatf("sw_data%0d", j),  fifo_data_out, 8'hA5);
            chk($sformatf("sw_busy%0d", j),  busy,          (j < 8) ? 1 : 0);
        end

        // back-to-back with in_valid held high
        n_hs     = 0;
        low_cnt  = 0;
        falls    = 0;
        prev_wr  = 1'b1;
        in_data  = bytes_q[0];
        in_valid = 1'b1;
        for (int c = 0; c < 30; c++) begin
            hs = in_valid && in_ready;
            if (hs && n_hs < 3) begin
                hs_c[n_hs] = c;
                n_hs++;
            end
            if (!fifo_wr_n) low_cnt++;
            if (prev_wr && !fifo_wr_n) falls++;
            prev_wr = fifo_wr_n;
            step();
            if (hs) begin
                chk($sformatf("b2b_data%0d", n_hs), fifo_data_out, bytes_q[n_hs-1]);
                if (n_hs < 3) in_data = bytes_q[n_hs];
                else          in_valid = 1'b0;
            end
        end
        chk("b2b_nhs",   n_hs, 3);
        chk("b2b_gap1",  hs_c[1] - hs_c[0], 9);
        chk("b2b_gap2",  hs_c[2] - hs_c[1], 9);
        chk("b2b_low",   low_cnt, 9);
        chk("b2b_falls", falls, 3);
        chk("b2b_count", write_count, 4);

        // full before the handshake
        nff_in = 1'b0;
        step();
        step();
        chk("ff_ready", in_ready, 0);
        in_valid = 1'b1;
        in_data  = 8'h5A;
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("ff_wr%0d", k),   fifo_wr_n, 1);
            chk($sformatf("ff_busy%0d", k), busy,      0);
        end
        nff_in = 1'b1;
        step();
        chk("ff_rel_ready0", in_ready, 0);
        step();
        chk("ff_rel_ready1", in_ready, 1);
        chk("ff_rel_busy",   busy,     0);
        step();
        in_valid = 1'b0;
        chk("ff_go_busy", busy,          1);
        chk("ff_go_data", fifo_data_out, 8'h5A);
        repeat (8) step();
        chk("ff_count", write_count, 5);
        chk("ff_ready_end", in_ready, 1);

        // full asserted during STROBE
        in_valid = 1'b1;
        in_data  = 8'h66;
        step();
        in_data  = 8'h77;
        step();
        nff_in   = 1'b0;
        step();
        chk("fs_wr_low", fifo_wr_n, 0);
        repeat (6) step();
        chk("fs_count", write_count,   6);
        chk("fs_ready", in_ready,      0);
        chk("fs_busy",  busy,          0);
        chk("fs_data",  fifo_data_out, 8'h66);
        repeat (3) step();
        chk("fs_hold_busy", busy,          0);
        chk("fs_hold_data", fifo_data_out, 8'h66);
        nff_in = 1'b1;
        step();
        chk("fs_rel_ready0", in_ready, 0);
        step();
        chk("fs_rel_ready1", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("fs_next_data", fifo_data_out, 8'h77);
        chk("fs_next_busy", busy,          1);
        repeat (8) step();
        chk("fs_count2", write_count, 7);

        // overridden timing on the second instance
        chk("ov_ready_pre", in_ready2, 1);
        in_valid2 = 1'b1;
        in_data2  = 8'h9C;
        step();
        in_valid2 = 1'b0;
        for (int j = 0; j <= 8; j++) begin
            if (j > 0) step();
            chk($sformatf("ov_wr%0d", j),  fifo_wr_n2,    (j == 2) ? 0 : 1);
            chk($sformatf("ov_oe%0d", j),  fifo_data_oe2, (j <= 3) ? 1 : 0);
            chk($sformatf("ov_rdy%0d", j), in_ready2,     (j == 8) ? 1 : 0);
        end
        chk("ov_count", write_count2,   1);
        chk("ov_data",  fifo_data_out2, 8'h9C);

        // write_count wrap
        force dut.r_write_count = 16'hFFFF;
        step();
        release dut.r_write_count;
        step();
        chk("wrap_pre", write_count, 16'hFFFF);
        in_valid = 1'b1;
        in_data  = 8'hE1;
        step();
        in_valid = 1'b0;
        repeat (8) step();
        chk("wrap_count", write_count,   16'h0000);
        chk("wrap_data",  fifo_data_out, 8'hE1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
